// File: rtl/vga_pattern_pkg.sv
// vga_pattern_pkg: shared mode encodings, palette, stage-1 bundle.
// Imported by vga_bar_pattern and vga_pat_frame_ctrl.
package vga_pattern_pkg;

  localparam logic [1:0] MODE_VBARS = 2'd0;
  localparam logic [1:0] MODE_HBARS = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  typedef logic [2:0] pal_idx_t;

  localparam pal_idx_t PAL_BLACK = 3'd0;
  localparam pal_idx_t PAL_WHITE = 3'd1;

  // first pipeline stage: enable plus palette index
  typedef struct packed {
    logic     de;
    pal_idx_t idx;
  } pix_t;

  // palette index -> {r,g,b} single-bit colour
  function automatic logic [2:0] pal_rgb(
    input pal_idx_t idx
  );
    logic [2:0] c;
    unique case (idx)
      3'd0:    c = 3'b000;
      3'd1:    c = 3'b111;
      3'd2:    c = 3'b100;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b001;
      3'd5:    c = 3'b011;
      3'd6:    c = 3'b101;
      default: c = 3'b110;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pat_frame_ctrl.sv
// vga_pat_frame_ctrl: per-frame shadow regs and bar rotation.
// In: clk, rst_n, frame_start_i, mode_i, shift_period_i, dir_i,
//   pause_i. Out: mode_o (frame mode), offset_o (bar rotation).
module vga_pat_frame_ctrl
  import vga_pattern_pkg::*;
#(
  parameter int NUM_BARS = 8,
  parameter int PER_W    = 8,
  localparam int BW      = $clog2(NUM_BARS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start_i,
  input  logic [1:0]       mode_i,
  input  logic [PER_W-1:0] shift_period_i,
  input  logic             dir_i,
  input  logic             pause_i,
  output logic [1:0]       mode_o,
  output logic [BW-1:0]    offset_o
);

  localparam logic [BW-1:0] LAST = BW'(NUM_BARS - 1);

  logic [1:0]       mode_q, mode_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    off_q, off_d;
  logic [BW-1:0]    off_inc, off_dec;

  assign off_inc = (off_q == LAST) ? '0 : off_q + BW'(1);
  assign off_dec = (off_q == '0) ? LAST : off_q - BW'(1);

  // counting uses the period latched at the previous frame start
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    if (frame_start_i) begin
      mode_d   = mode_i;
      period_d = shift_period_i;
      if (period_q == '0) begin
        cnt_d = '0;
      end else if (!pause_i) begin
        if (cnt_q == period_q - PER_W'(1)) begin
          cnt_d = '0;
          off_d = dir_i ? off_dec : off_inc;
        end else begin
          cnt_d = cnt_q + PER_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_VBARS;
      period_q <= '0;
      cnt_q    <= '0;
      off_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
    end
  end

  assign mode_o   = mode_q;
  assign offset_o = off_q;

endmodule

// File: rtl/vga_bar_pattern.sv
// vga_bar_pattern: VGA test pattern, bars/checker/solid, 2-cycle pipe.
// In: clk, rst_n, de, frame_start, mode, shift_period, dir, pause.
// Out: o_r/o_g/o_b colour, o_de. Define VGA_PAT_BORDER_EN for a
//   1-pixel white frame border.
module vga_bar_pattern
  import vga_pattern_pkg::*;
#(
  parameter int NUM_BARS = 8,
  parameter int COLOR_W  = 4,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PER_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de,
  input  logic               frame_start,
  input  logic [1:0]         mode,
  input  logic [PER_W-1:0]   shift_period,
  input  logic               dir,
  input  logic               pause,
  output logic [COLOR_W-1:0] o_r,
  output logic [COLOR_W-1:0] o_g,
  output logic [COLOR_W-1:0] o_b,
  output logic               o_de
);

  localparam int BW    = $clog2(NUM_BARS);
  localparam int XW    = $clog2(H_ACTIVE + 1);
  localparam int YW    = $clog2(V_ACTIVE + 1);
  localparam int BAR_W = H_ACTIVE / NUM_BARS;
  localparam int BAR_H = V_ACTIVE / NUM_BARS;
  localparam logic [BW-1:0] LAST = BW'(NUM_BARS - 1);

  logic [1:0]    mode_q;
  logic [BW-1:0] off;

  vga_pat_frame_ctrl #(
    .NUM_BARS (NUM_BARS),
    .PER_W    (PER_W)
  ) u_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start_i  (frame_start),
    .mode_i         (mode),
    .shift_period_i (shift_period),
    .dir_i          (dir),
    .pause_i        (pause),
    .mode_o         (mode_q),
    .offset_o       (off)
  );

  logic          de_q;
  logic          line_ok_q, line_ok_d;
  logic [XW-1:0] x_q, x_d, xe_q, xe_d;
  logic [YW-1:0] y_q, y_d, ye_q, ye_d;
  logic [BW-1:0] bar_x_q, bar_x_d;
  logic [BW-1:0] bar_y_q, bar_y_d;
  pix_t          pix_q, pix_d;
  logic [COLOR_W-1:0] o_r_q, o_g_q, o_b_q;
  logic          o_de_q;
  logic [2:0]    rgb;

  // xe/ye hold the last coordinate of the current bar
  always_comb begin
    x_d     = x_q;
    xe_d    = xe_q;
    bar_x_d = bar_x_q;
    if (!de) begin
      x_d     = '0;
      xe_d    = XW'(BAR_W - 1);
      bar_x_d = '0;
    end else begin
      x_d = x_q + XW'(1);
      if (x_q == xe_q && bar_x_q != LAST) begin
        bar_x_d = bar_x_q + BW'(1);
        xe_d    = xe_q + XW'(BAR_W);
      end
    end
  end

  always_comb begin
    y_d     = y_q;
    ye_d    = ye_q;
    bar_y_d = bar_y_q;
    if (frame_start) begin
      y_d     = '0;
      ye_d    = YW'(BAR_H - 1);
      bar_y_d = '0;
    end else if (de_q && !de) begin
      y_d = y_q + YW'(1);
      if (y_q == ye_q && bar_y_q != LAST) begin
        bar_y_d = bar_y_q + BW'(1);
        ye_d    = ye_q + YW'(BAR_H);
      end
    end
  end

  // after a reset the partial line in flight stays black
  assign line_ok_d = line_ok_q | ~de;

  function automatic pal_idx_t rot(
    input logic [BW-1:0] b,
    input logic [BW-1:0] o
  );
    logic [BW:0] s;
    s = {1'b0, b} + {1'b0, o};
    if (s >= (BW+1)'(NUM_BARS)) begin
      s = s - (BW+1)'(NUM_BARS);
    end
    return 3'(s);
  endfunction

  always_comb begin
    pix_d     = '0;
    pix_d.de  = de;
    unique case (1'b1)
      mode_q == MODE_VBARS:
        pix_d.idx = rot(bar_x_q, off);
      mode_q == MODE_HBARS:
        pix_d.idx = rot(bar_y_q, off);
      mode_q == MODE_CHECK:
        pix_d.idx = (bar_x_q[0] ^ bar_y_q[0] ^ off[0])
                    ? PAL_WHITE : PAL_BLACK;
      default:
        pix_d.idx = 3'(off);
    endcase
`ifdef VGA_PAT_BORDER_EN
    if (x_q == '0 || x_q == XW'(H_ACTIVE - 1) ||
        y_q == '0 || y_q == YW'(V_ACTIVE - 1)) begin
      pix_d.idx = PAL_WHITE;
    end
`endif
    if (!line_ok_q) begin
      pix_d.idx = PAL_BLACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q      <= 1'b0;
      line_ok_q <= 1'b0;
      x_q       <= '0;
      xe_q      <= XW'(BAR_W - 1);
      bar_x_q   <= '0;
      y_q       <= '0;
      ye_q      <= YW'(BAR_H - 1);
      bar_y_q   <= '0;
      pix_q     <= '0;
    end else begin
      de_q      <= de;
      line_ok_q <= line_ok_d;
      x_q       <= x_d;
      xe_q      <= xe_d;
      bar_x_q   <= bar_x_d;
      y_q       <= y_d;
      ye_q      <= ye_d;
      bar_y_q   <= bar_y_d;
      pix_q     <= pix_d;
    end
  end

  assign rgb = pal_rgb(pix_q.idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_r_q  <= '0;
      o_g_q  <= '0;
      o_b_q  <= '0;
      o_de_q <= 1'b0;
    end else begin
      o_r_q  <= pix_q.de ? {COLOR_W{rgb[2]}} : '0;
      o_g_q  <= pix_q.de ? {COLOR_W{rgb[1]}} : '0;
      o_b_q  <= pix_q.de ? {COLOR_W{rgb[0]}} : '0;
      o_de_q <= pix_q.de;
    end
  end

  assign o_r  = o_r_q;
  assign o_g  = o_g_q;
  assign o_b  = o_b_q;
  assign o_de = o_de_q;

endmodule

// File: tb/tb_vga_bar_pattern.sv
// tb_vga_bar_pattern: 8-bar and 6-bar instances vs behavioural model.
// Directed pattern checks then randomized frames.
module tb_vga_bar_pattern;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       de = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] shift_period = 8'd0;
  logic       dir = 1'b0;
  logic       pause = 1'b0;

  logic [3:0] r8, g8, b8, r6, g6, b6;
  logic       de8, de6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_bar_pattern #(
    .NUM_BARS(8), .COLOR_W(4), .H_ACTIVE(640),
    .V_ACTIVE(480), .PER_W(8)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .de(de),
    .frame_start(frame_start), .mode(mode),
    .shift_period(shift_period), .dir(dir), .pause(pause),
    .o_r(r8), .o_g(g8), .o_b(b8), .o_de(de8)
  );

  vga_bar_pattern #(
    .NUM_BARS(6), .COLOR_W(4), .H_ACTIVE(640),
    .V_ACTIVE(480), .PER_W(8)
  ) u_dut6 (
    .clk(clk), .rst_n(rst_n), .de(de),
    .frame_start(frame_start), .mode(mode),
    .shift_period(shift_period), .dir(dir), .pause(pause),
    .o_r(r6), .o_g(g6), .o_b(b6), .o_de(de6)
  );

  typedef struct packed {
    logic        de;
    logic [11:0] c0;
    logic [11:0] c1;
    logic        l0;
    logic [11:0] v0;
    logic        l1;
    logic [11:0] v1;
  } exp_t;

  exp_t q[$];
  logic [11:0] want0[int];
  logic [11:0] want1[int];
  int lit_req = 0;
  int lit_seen = 0;

  // model state: screen position, frame settings, rotation
  int x_m, y_m, mode_m, per_m, cnt_m;
  int off_m[2];
  bit dep_m, lok_m;

  function automatic logic [11:0] pal12(input int i);
    case (i)
      0: return 12'h000;
      1: return 12'hFFF;
      2: return 12'hF00;
      3: return 12'h0F0;
      4: return 12'h00F;
      5: return 12'h0FF;
      6: return 12'hF0F;
      default: return 12'hFF0;
    endcase
  endfunction

  function automatic logic [11:0] model_rgb(input int k);
    int nb, bx, by, o;
    nb = (k == 0) ? 8 : 6;
    o  = off_m[k];
    bx = x_m / (640 / nb);
    if (bx > nb - 1) bx = nb - 1;
    by = y_m / (480 / nb);
    if (by > nb - 1) by = nb - 1;
    if (!lok_m) return 12'h000;
`ifdef VGA_PAT_BORDER_EN
    if (x_m == 0 || x_m == 639 || y_m == 0 || y_m == 479)
      return 12'hFFF;
`endif
    case (mode_m)
      0: return pal12(((bx + o) % nb) % 8);
      1: return pal12(((by + o) % nb) % 8);
      2: return (((bx ^ by ^ o) & 1) != 0) ? 12'hFFF : 12'h000;
      default: return pal12(o % 8);
    endcase
  endfunction

  function automatic void model_reset();
    x_m = 0; y_m = 0; mode_m = 0; per_m = 0; cnt_m = 0;
    off_m[0] = 0; off_m[1] = 0;
    dep_m = 1'b0; lok_m = 1'b0;
  endfunction

  function automatic void model_step();
    int nb;
    if (frame_start) begin
      if (per_m == 0) begin
        cnt_m = 0;
      end else if (!pause) begin
        if (cnt_m == per_m - 1) begin
          cnt_m = 0;
          for (int k = 0; k < 2; k++) begin
            nb = (k == 0) ? 8 : 6;
            off_m[k] = dir ? (off_m[k] + nb - 1) % nb
                           : (off_m[k] + 1) % nb;
          end
        end else begin
          cnt_m = (cnt_m + 1) % 256;
        end
      end
      mode_m = int'(mode);
      per_m  = int'(shift_period);
    end
    if (frame_start) y_m = 0;
    else if (dep_m && !de) y_m = y_m + 1;
    x_m   = de ? x_m + 1 : 0;
    lok_m = lok_m || !de;
    dep_m = de;
  endfunction

  // expectation for each sampled input cycle, aged by two edges
  initial begin
    exp_t e;
    model_reset();
    q.push_back('0);
    q.push_back('0);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        q.delete();
        q.push_back('0);
        q.push_back('0);
      end else begin
        e = '0;
        e.de = de;
        if (de) begin
          e.c0 = model_rgb(0);
          e.c1 = model_rgb(1);
          if (want0.exists(x_m)) begin
            e.l0 = 1'b1;
            e.v0 = want0[x_m];
          end
          if (want1.exists(x_m)) begin
            e.l1 = 1'b1;
            e.v1 = want1[x_m];
          end
        end
        q.push_back(e);
        void'(q.pop_front());
        model_step();
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checks++;
        if ({de8, r8, g8, b8, de6, r6, g6, b6} !== 26'd0) begin
          errors++;
          $display("FAIL reset_out t=%0t got %h/%h required 0",
                   $time, {de8, r8, g8, b8}, {de6, r6, g6, b6});
        end
      end else if (q.size() > 0) begin
        e = q[0];
        checks++;
        if ({de8, r8, g8, b8} !== {e.de, e.c0}) begin
          errors++;
          $display("FAIL pix8 t=%0t got %h required %h",
                   $time, {de8, r8, g8, b8}, {e.de, e.c0});
        end
        checks++;
        if ({de6, r6, g6, b6} !== {e.de, e.c1}) begin
          errors++;
          $display("FAIL pix6 t=%0t got %h required %h",
                   $time, {de6, r6, g6, b6}, {e.de, e.c1});
        end
        if (e.l0) begin
          lit_seen++;
          checks++;
          if ({de8, r8, g8, b8} !== {1'b1, e.v0}) begin
            errors++;
            $display("FAIL lit8 t=%0t got %h required %h",
                     $time, {de8, r8, g8, b8}, {1'b1, e.v0});
          end
        end
        if (e.l1) begin
          lit_seen++;
          checks++;
          if ({de6, r6, g6, b6} !== {1'b1, e.v1}) begin
            errors++;
            $display("FAIL lit6 t=%0t got %h required %h",
                     $time, {de6, r6, g6, b6}, {1'b1, e.v1});
          end
        end
      end
    end
  end

  task automatic tick(input logic d, input logic fs);
    @(negedge clk);
    de = d;
    frame_start = fs;
  endtask

  task automatic fstart();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic line(input int len);
    for (int i = 0; i < len; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    want0.delete();
    want1.delete();
  endtask

  task automatic want(input int k, input int x,
                      input logic [11:0] v);
    if (k == 0) want0[x] = v;
    else want1[x] = v;
    lit_req++;
  endtask

  task automatic chk_off(input string nm, input int a, input int b);
    checks++;
    if (off_m[0] != a || off_m[1] != b) begin
      errors++;
      $display("FAIL %s model offsets %0d/%0d required %0d/%0d",
               nm, off_m[0], off_m[1], a, b);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) tick(1'b0, 1'b0);

    // defaults, static vertical bars
    fstart();
    want(0, 79, 12'h000);
    want(0, 80, 12'hFFF);
    want(0, 639, 12'hFF0);
    want(1, 529, 12'h00F);
    want(1, 530, 12'h0FF);
    want(1, 639, 12'h0FF);
    line(640);

    // period 2, rotate right
    shift_period = 8'd2;
    fstart();
    repeat (2) fstart();
    chk_off("per2_a", 1, 1);
    want(0, 0, 12'hFFF);
    want(1, 0, 12'hFFF);
    line(640);
    repeat (14) fstart();
    chk_off("per2_b", 0, 2);
    want(0, 0, 12'h000);
    want(1, 0, 12'hF00);
    line(640);

    // period 1, rotate left, then pause
    shift_period = 8'd0;
    repeat (2) fstart();
    shift_period = 8'd1;
    dir = 1'b1;
    repeat (2) fstart();
    chk_off("per1_left", 7, 1);
    want(0, 0, 12'hFF0);
    want(1, 0, 12'hFFF);
    line(640);
    pause = 1'b1;
    repeat (5) fstart();
    chk_off("pause", 7, 1);
    want(0, 0, 12'hFF0);
    want(1, 0, 12'hFFF);
    line(640);

    // asynchronous reset in the middle of a line
    repeat (50) tick(1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({de8, r8, g8, b8, de6, r6, g6, b6} !== 26'd0) begin
      errors++;
      $display("FAIL async_reset got %h/%h required 0",
               {de8, r8, g8, b8}, {de6, r6, g6, b6});
    end
    repeat (2) tick(1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (30) tick(1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    chk_off("after_reset", 0, 0);

    // checkerboard, then mid-frame mode write
    pause = 1'b0;
    dir = 1'b0;
    shift_period = 8'd0;
    mode = 2'd2;
    fstart();
    want(0, 80, 12'hFFF);
    want(1, 106, 12'hFFF);
    line(640);
    mode = 2'd0;
    want(0, 160, 12'h000);
    want(1, 212, 12'h000);
    line(640);
    fstart();
    want(0, 160, 12'hF00);
    want(1, 212, 12'hF00);
    line(640);

    // full-height frame: corners
    fstart();
`ifdef VGA_PAT_BORDER_EN
    want(0, 0, 12'hFFF);
    want(1, 0, 12'hFFF);
`else
    want(0, 0, 12'h000);
    want(1, 0, 12'h000);
`endif
    line(640);
    want(0, 1, 12'h000);
    want(1, 1, 12'h000);
    line(640);
    repeat (477) line(1);
`ifdef VGA_PAT_BORDER_EN
    want(0, 639, 12'hFFF);
    want(1, 639, 12'hFFF);
`else
    want(0, 639, 12'hFF0);
    want(1, 639, 12'h0FF);
`endif
    line(640);

    // randomized frames with mid-frame setting changes
    for (int f = 0; f < 40; f++) begin
      mode = 2'($urandom_range(0, 3));
      shift_period = 8'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      pause = ($urandom_range(0, 3) == 0);
      fstart();
      for (int l = 0; l < int'($urandom_range(0, 2)); l++) begin
        mode = 2'($urandom_range(0, 3));
        dir = 1'($urandom_range(0, 1));
        line(int'($urandom_range(1, 660)));
      end
    end

    repeat (4) tick(1'b0, 1'b0);
    checks++;
    if (lit_seen != lit_req) begin
      errors++;
      $display("FAIL lit_count got %0d required %0d",
               lit_seen, lit_req);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
